// File: rtl/regfile_write_arbiter.sv
// Write-port controller for a 4 x 32-bit register file: round-robin arbitration
// between two requesters plus a four-cycle clear-all sequence.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clear_req,
    output logic                  rf_regWrite,
    output logic [ADDR_WIDTH-1:0] rf_writeReg,
    output logic [DATA_WIDTH-1:0] rf_writeData,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [3:0]            busy
);

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned NUM_REGS = 4;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  grant0, grant1;

    // Round-robin grant; a tie goes to the requester that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ARB && !clear_req) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        done_d       = 1'b0;
        case (state_q)
            ARB: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    wreg_d  = '0;
                    wdata_d = '0;
                    cnt_d   = CNT_W'(1);
                end else if (grant0) begin
                    we_d         = 1'b1;
                    wreg_d       = req0_reg;
                    wdata_d      = req0_data;
                    last_grant_d = 1'b0;
                end else if (grant1) begin
                    we_d         = 1'b1;
                    wreg_d       = req1_reg;
                    wdata_d      = req1_data;
                    last_grant_d = 1'b1;
                end
            end
            CLEAR: begin
                we_d    = 1'b1;
                wreg_d  = ADDR_WIDTH'(cnt_q);
                wdata_d = '0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NUM_REGS - 1)) begin
                    state_d = ARB;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            wreg_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign clear_busy   = (state_q == CLEAR) || clear_req;
    assign rf_regWrite  = we_q;
    assign rf_writeReg  = wreg_q;
    assign rf_writeData = wdata_q;
    assign clear_done   = done_q;
    assign busy         = we_q ? 4'(4'b0001 << wreg_q) : 4'b0000;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, clear
// corner sequences and randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, clear_req;
    logic [1:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_regWrite, clear_busy, clear_done;
    logic [1:0]  rf_writeReg;
    logic [31:0] rf_writeData;
    logic [3:0]  busy;

    int n_pass = 0;
    int n_total = 0;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .clear_req(clear_req), .rf_regWrite(rf_regWrite), .rf_writeReg(rf_writeReg),
        .rf_writeData(rf_writeData), .clear_busy(clear_busy), .clear_done(clear_done), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v0;
        logic [1:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [1:0]  r1;
        logic [31:0] d1;
        logic        clr;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_cb;
        logic        e_we;
        logic [1:0]  e_reg;
        logic [31:0] e_data;
        logic        e_done;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mkv(logic v0, logic [1:0] r0, logic [31:0] d0,
                                 logic v1, logic [1:0] r1, logic [31:0] d1, logic clr,
                                 logic e_rdy0, logic e_rdy1, logic e_cb,
                                 logic e_we, logic [1:0] e_reg, logic [31:0] e_data, logic e_done);
        vec_t v;
        v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1; v.clr = clr;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_cb = e_cb;
        v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Combinational outputs, checked before the edge of the current cycle.
    task automatic chk_comb(string tag, logic e_rdy0, logic e_rdy1, logic e_cb);
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(e_rdy0));
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(e_rdy1));
        chk({tag, ".clear_busy"}, 32'(clear_busy), 32'(e_cb));
    endtask

    // Registered outputs plus the derived busy vector.
    task automatic chk_out(string tag, logic e_we, logic [1:0] e_reg, logic [31:0] e_data, logic e_done);
        logic [3:0] e_busy;
        e_busy = e_we ? (4'b0001 << e_reg) : 4'b0000;
        chk({tag, ".rf_regWrite"}, 32'(rf_regWrite), 32'(e_we));
        chk({tag, ".rf_writeReg"}, 32'(rf_writeReg), 32'(e_reg));
        chk({tag, ".rf_writeData"}, rf_writeData, e_data);
        chk({tag, ".clear_done"}, 32'(clear_done), 32'(e_done));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; clear_req = 1'b0;
        req0_reg = '0; req1_reg = '0; req0_data = '0; req1_data = '0;
    endtask

    // Reference model state for the random phase.
    int          clr_q[$];
    logic        m_last;
    logic        m_we, m_done;
    logic [1:0]  m_reg;
    logic [31:0] m_data;

    initial begin
        idle_inputs();
        reset = 1'b0;
        #2;
        chk_out("reset", 1'b0, 2'd0, 32'd0, 1'b0);
        chk("reset.clear_busy", 32'(clear_busy), 32'd0);
        #10 reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed table: single grants, idle hold, alternating ties.
        vecs[0] = mkv(1, 2'd2, 32'd15, 0, 2'd0, 32'd0,  0, 1, 0, 0, 1, 2'd2, 32'd15, 0);
        vecs[1] = mkv(0, 2'd0, 32'd0,  1, 2'd3, 32'd7,  0, 0, 1, 0, 1, 2'd3, 32'd7,  0);
        vecs[2] = mkv(0, 2'd0, 32'd0,  0, 2'd0, 32'd0,  0, 0, 0, 0, 0, 2'd3, 32'd7,  0);
        vecs[3] = mkv(0, 2'd0, 32'd0,  0, 2'd0, 32'd0,  0, 0, 0, 0, 0, 2'd3, 32'd7,  0);
        vecs[4] = mkv(0, 2'd0, 32'd0,  0, 2'd0, 32'd0,  0, 0, 0, 0, 0, 2'd3, 32'd7,  0);
        vecs[5] = mkv(1, 2'd1, 32'd10, 1, 2'd3, 32'd20, 0, 1, 0, 0, 1, 2'd1, 32'd10, 0);
        vecs[6] = mkv(1, 2'd1, 32'd11, 1, 2'd3, 32'd20, 0, 0, 1, 0, 1, 2'd3, 32'd20, 0);
        vecs[7] = mkv(1, 2'd1, 32'd11, 1, 2'd3, 32'd21, 0, 1, 0, 0, 1, 2'd1, 32'd11, 0);
        vecs[8] = mkv(1, 2'd1, 32'd12, 1, 2'd3, 32'd21, 0, 0, 1, 0, 1, 2'd3, 32'd21, 0);
        for (int i = 0; i < 9; i++) begin
            req0_valid = vecs[i].v0; req0_reg = vecs[i].r0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_reg = vecs[i].r1; req1_data = vecs[i].d1;
            clear_req  = vecs[i].clr;
            #1;
            chk_comb($sformatf("vec%0d", i), vecs[i].e_rdy0, vecs[i].e_rdy1, vecs[i].e_cb);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_reg, vecs[i].e_data, vecs[i].e_done);
        end
        idle_inputs();

        // Single clear pulse with req1 held valid: accepted in the clear_done cycle.
        for (int k = 0; k < 5; k++) begin
            clear_req = (k == 0);
            req1_valid = 1'b1; req1_reg = 2'd2; req1_data = 32'h55;
            #1;
            chk_comb($sformatf("clrpulse%0d", k), 1'b0, k == 4, k < 4);
            tick();
            if (k < 4) chk_out($sformatf("clrpulse%0d", k), 1'b1, 2'(k), 32'd0, k == 3);
            else       chk_out("clrpulse4", 1'b1, 2'd2, 32'h55, 1'b0);
        end
        idle_inputs();

        // clear_req held for 6 cycles: back-to-back sequences.
        for (int k = 0; k < 9; k++) begin
            clear_req = (k < 6);
            #1;
            chk_comb($sformatf("clrhold%0d", k), 1'b0, 1'b0, k < 8);
            tick();
            if (k < 8) chk_out($sformatf("clrhold%0d", k), 1'b1, 2'(k % 4), 32'd0, (k % 4) == 3);
            else       chk_out("clrhold8", 1'b0, 2'd3, 32'd0, 1'b0);
        end
        idle_inputs();

        // Asynchronous reset after reg 1 has been emitted.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        chk_out("midclr.pre", 1'b1, 2'd1, 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_out("midclr.rst", 1'b0, 2'd0, 32'd0, 1'b0);
        chk("midclr.rst.clear_busy", 32'(clear_busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("midclr.post%0d", k), 1'b0, 2'd0, 32'd0, 1'b0);
        end

        // Randomized traffic against a queue-based model, starting from reset state.
        m_last = 1'b1; m_we = 1'b0; m_done = 1'b0; m_reg = '0; m_data = '0;
        clr_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic in_clr, g0, g1;
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1'b1; req0_reg = 2'($urandom_range(0, 3)); req0_data = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1'b1; req1_reg = 2'($urandom_range(0, 3)); req1_data = $urandom;
            end
            clear_req = ($urandom_range(0, 11) == 0);
            in_clr = (clr_q.size() != 0);
            g0 = 1'b0; g1 = 1'b0;
            if (!in_clr && !clear_req) begin
                g0 = req0_valid && (!req1_valid || m_last);
                g1 = req1_valid && !g0;
            end
            #1;
            chk_comb($sformatf("rnd%0d", c), g0, g1, in_clr || clear_req);
            m_done = 1'b0;
            if (in_clr) begin
                m_we = 1'b1; m_reg = 2'(clr_q.pop_front()); m_data = '0;
                m_done = (clr_q.size() == 0);
            end else if (clear_req) begin
                m_we = 1'b1; m_reg = 2'd0; m_data = '0;
                clr_q.push_back(1); clr_q.push_back(2); clr_q.push_back(3);
            end else if (g0) begin
                m_we = 1'b1; m_reg = req0_reg; m_data = req0_data; m_last = 1'b0;
            end else if (g1) begin
                m_we = 1'b1; m_reg = req1_reg; m_data = req1_data; m_last = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            tick();
            chk_out($sformatf("rnd%0d", c), m_we, m_reg, m_data, m_done);
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
